// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO controller.
package fifo_pkg;

    localparam int unsigned WIDTH_ADDR_DEF    = 8;
    localparam int unsigned AFULL_THRESH_DEF  = 240;
    localparam int unsigned AEMPTY_THRESH_DEF = 16;

    // Number of RAM words addressed by width_addr bits.
    function automatic int unsigned fifo_depth(input int unsigned width_addr);
        return 32'd1 << width_addr;
    endfunction

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int unsigned ptr_width(input int unsigned width_addr);
        return width_addr + 1;
    endfunction

    localparam int unsigned PTR_W_DEF = WIDTH_ADDR_DEF + 1;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous clear.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_W = PTR_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [PTR_W-1:0] o_ptr,
    output logic [PTR_W-1:0] o_ptr_next
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear wins, otherwise natural modulo-2**PTR_W increment.
    always_comb begin
        ptr_d = ptr_q;
        if (i_clr) begin
            ptr_d = '0;
        end else if (i_inc) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr      = ptr_q;
    assign o_ptr_next = ptr_d;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller sequencing one dual-port RAM; carries no data.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR    = WIDTH_ADDR_DEF,
    parameter int unsigned AFULL_THRESH  = AFULL_THRESH_DEF,
    parameter int unsigned AEMPTY_THRESH = AEMPTY_THRESH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_req,
    input  logic                  i_rd_req,
    input  logic                  i_clr,
    input  logic                  i_err_clr,
    output logic                  o_ram_wr_en,
    output logic [WIDTH_ADDR-1:0] o_ram_waddr,
    output logic                  o_ram_rd_en,
    output logic [WIDTH_ADDR-1:0] o_ram_raddr,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_afull,
    output logic                  o_aempty,
    output logic [WIDTH_ADDR:0]   o_count,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int unsigned PTR_W    = ptr_width(WIDTH_ADDR);
    localparam logic [PTR_W-1:0] AFULL_T  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_T = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wptr, wptr_next;
    logic [PTR_W-1:0] rptr, rptr_next;
    logic [PTR_W-1:0] count_q, count_d;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             full_d, empty_d;
    logic             rd_valid_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             wr_acc, rd_acc;

    // Accepts are judged against the registered flags; a flush blocks both.
    assign wr_acc = i_wr_req & ~full_q  & ~i_clr;
    assign rd_acc = i_rd_req & ~empty_q & ~i_clr;

    fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_wptr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc      (wr_acc),
        .i_clr      (i_clr),
        .o_ptr      (wptr),
        .o_ptr_next (wptr_next)
    );

    fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_rptr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc      (rd_acc),
        .i_clr      (i_clr),
        .o_ptr      (rptr),
        .o_ptr_next (rptr_next)
    );

    // Next occupancy and pointer-relation flags for the post-edge state.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (wr_acc && !rd_acc) begin
            count_d = count_q + PTR_W'(1);
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - PTR_W'(1);
        end
        empty_d = (wptr_next == rptr_next);
        full_d  = (wptr_next[WIDTH_ADDR-1:0] == rptr_next[WIDTH_ADDR-1:0]) &&
                  (wptr_next[WIDTH_ADDR] != rptr_next[WIDTH_ADDR]);
    end

    // Occupancy, status flags and read-valid pipeline stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= (count_d >= AFULL_T);
            aempty_q   <= (count_d <= AEMPTY_T);
            rd_valid_q <= rd_acc;
        end
    end

    // Sticky errors: a new violation outranks a simultaneous clear.
    always_comb begin
        ovf_d = (i_wr_req & full_q  & ~i_clr) | (ovf_q & ~i_err_clr);
        udf_d = (i_rd_req & empty_q & ~i_clr) | (udf_q & ~i_err_clr);
    end

    // Error flag registers; untouched by the synchronous flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Enables drop the moment reset asserts, before the flags have settled.
    assign o_ram_wr_en = wr_acc & i_rst_n;
    assign o_ram_rd_en = rd_acc & i_rst_n;
    assign o_ram_waddr = wptr[WIDTH_ADDR-1:0];
    assign o_ram_raddr = rptr[WIDTH_ADDR-1:0];

    assign o_rd_valid = rd_valid_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_afull    = afull_q;
    assign o_aempty   = aempty_q;
    assign o_count    = count_q;
    assign o_ovf      = ovf_q;
    assign o_udf      = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized bench for sync_fifo_ctrl with a queue-based FIFO model and a RAM model.
module tb_sync_fifo_ctrl;

    localparam int unsigned WA    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFT   = 14;
    localparam int unsigned AET   = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_wr_req = 1'b0;
    logic          i_rd_req = 1'b0;
    logic          i_clr = 1'b0;
    logic          i_err_clr = 1'b0;
    logic          o_ram_wr_en, o_ram_rd_en;
    logic [WA-1:0] o_ram_waddr, o_ram_raddr;
    logic          o_rd_valid, o_full, o_empty, o_afull, o_aempty, o_ovf, o_udf;
    logic [WA:0]   o_count;

    always #5 i_clk = ~i_clk;

    sync_fifo_ctrl #(
        .WIDTH_ADDR    (WA),
        .AFULL_THRESH  (AFT),
        .AEMPTY_THRESH (AET)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_req    (i_wr_req),
        .i_rd_req    (i_rd_req),
        .i_clr       (i_clr),
        .i_err_clr   (i_err_clr),
        .o_ram_wr_en (o_ram_wr_en),
        .o_ram_waddr (o_ram_waddr),
        .o_ram_rd_en (o_ram_rd_en),
        .o_ram_raddr (o_ram_raddr),
        .o_rd_valid  (o_rd_valid),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_afull     (o_afull),
        .o_aempty    (o_aempty),
        .o_count     (o_count),
        .o_ovf       (o_ovf),
        .o_udf       (o_udf)
    );

    // RAM with registered read, driven only by the controller's enables/addresses
    logic [7:0] mem [DEPTH];
    logic [7:0] ram_rdata;
    logic [7:0] wdata = 8'h00;

    always @(posedge i_clk) begin
        if (o_ram_wr_en) mem[o_ram_waddr] <= wdata;
        if (o_ram_rd_en) ram_rdata <= mem[o_ram_raddr];
    end

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: occupancy, pointer positions, stored words, sticky errors
    int         m_count = 0;
    int         m_wptr  = 0;
    int         m_rptr  = 0;
    bit         m_ovf   = 0;
    bit         m_udf   = 0;
    bit         m_rv    = 0;
    logic [7:0] m_exp_rd = 8'h00;
    logic [7:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wptr  = 0;
        m_rptr  = 0;
        m_ovf   = 0;
        m_udf   = 0;
        m_rv    = 0;
        m_q.delete();
    endtask

    // One clock cycle: drive, check everything against the model, advance the model
    task automatic step(input bit wr, input bit rd, input bit clr, input bit eclr,
                        input logic [7:0] d);
        bit wa, ra, set_o, set_u;
        @(negedge i_clk);
        i_wr_req  = wr;
        i_rd_req  = rd;
        i_clr     = clr;
        i_err_clr = eclr;
        wdata     = d;
        #1;
        wa    = wr && (m_count != DEPTH) && !clr;
        ra    = rd && (m_count != 0) && !clr;
        set_o = wr && (m_count == DEPTH) && !clr;
        set_u = rd && (m_count == 0) && !clr;
        check("count",  o_count,  m_count);
        check("full",   o_full,   m_count == DEPTH);
        check("empty",  o_empty,  m_count == 0);
        check("afull",  o_afull,  m_count >= AFT);
        check("aempty", o_aempty, m_count <= AET);
        check("ovf",    o_ovf,    m_ovf);
        check("udf",    o_udf,    m_udf);
        check("rd_valid", o_rd_valid, m_rv);
        if (m_rv) check("rdata", ram_rdata, m_exp_rd);
        check("wr_en", o_ram_wr_en, wa);
        check("rd_en", o_ram_rd_en, ra);
        check("waddr", o_ram_waddr, m_wptr % DEPTH);
        check("raddr", o_ram_raddr, m_rptr % DEPTH);
        @(posedge i_clk);
        m_ovf = set_o || (m_ovf && !eclr);
        m_udf = set_u || (m_udf && !eclr);
        if (clr) begin
            m_count = 0;
            m_wptr  = 0;
            m_rptr  = 0;
            m_q.delete();
        end else begin
            if (ra) m_exp_rd = m_q.pop_front();
            if (wa) m_q.push_back(d);
            m_count = m_count + int'(wa) - int'(ra);
            m_wptr  = (m_wptr + int'(wa)) % (2 * DEPTH);
            m_rptr  = (m_rptr + int'(ra)) % (2 * DEPTH);
        end
        m_rv = ra;
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();

        // Fill 16: flags walk through aempty/afull/full, waddr 0..15
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i));
        step(0, 0, 0, 0, 8'h00);

        // Push at full: rejected, ovf sticky until err_clr
        step(1, 0, 0, 0, 8'h55);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Push + pop at full: pop wins, ovf set, valid next cycle
        step(1, 1, 0, 0, 8'h66);
        step(0, 0, 0, 1, 8'h00);

        // Flush, fill A0..AF, drain all 16, then stream 20 push/pop cycles
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 8'hC0 + 8'(i));
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);

        // Push + pop on empty: push wins, udf set
        step(1, 1, 0, 0, 8'h77);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);

        // Reach count 9, then flush with push asserted
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'(i + 16));
        step(1, 1, 1, 0, 8'hEE);
        step(0, 0, 0, 0, 8'h00);

        // Randomized traffic, phases biased toward filling and draining
        for (int ph = 0; ph < 8; ph++) begin
            int pw, pr;
            pw = (ph % 2 == 0) ? 75 : 30;
            pr = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 80; i++) begin
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                     8'($urandom));
            end
        end

        // Fill partway, then pull reset mid-cycle with requests held high
        for (int i = 0; i < 6; i++) step(1, i > 2, 0, 0, 8'(i + 48));
        step(1, 1, 0, 0, 8'h99);
        @(negedge i_clk);
        i_wr_req = 1'b1;
        i_rd_req = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst count",  o_count, 0);
        check("rst empty",  o_empty, 1);
        check("rst full",   o_full, 0);
        check("rst afull",  o_afull, 0);
        check("rst aempty", o_aempty, 1);
        check("rst valid",  o_rd_valid, 0);
        check("rst ovf",    o_ovf, 0);
        check("rst udf",    o_udf, 0);
        check("rst wr_en",  o_ram_wr_en, 0);
        check("rst rd_en",  o_ram_rd_en, 0);
        check("rst waddr",  o_ram_waddr, 0);
        check("rst raddr",  o_ram_raddr, 0);
        @(negedge i_clk);
        i_wr_req = 1'b0;
        i_rd_req = 1'b0;
        i_rst_n  = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
